victim_cache_plru: RTL and testbench

Replacement-way generator for the 8-way fully-associative victim cache. It tracks the victim cache's tree pseudo-LRU state and presents the way that the next insertion must overwrite. That way drives the tag array's `address_way_i` directly. It also keeps saturating hit and fill counters for performance monitoring.

---
 rtl/victim_cache_plru_if.sv | 28 ++
 rtl/victim_cache_plru.sv | 90 +++++++++
 tb/tb_victim_cache_plru.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/victim_cache_plru_if.sv
// Bundles the victim cache's hit/fill event inputs and the replacement-way and
// performance-counter outputs of victim_cache_plru.
interface victim_cache_plru_if #(
  parameter int unsigned WAYS  = 8,
  parameter int unsigned WAY_W = 3,
  parameter int unsigned CNT_W = 16
);
  logic             hit_i;
  logic [WAY_W-1:0] hit_way_i;
  logic             fill_i;
  logic [WAY_W-1:0] fill_way_i;
  logic [WAYS-1:0]  valid_mask_i;
  logic             flush_i;
  logic [WAY_W-1:0] victim_way_o;
  logic             full_o;
  logic [CNT_W-1:0] hit_cnt_o;
  logic [CNT_W-1:0] fill_cnt_o;

  modport master (
    output hit_i, hit_way_i, fill_i, fill_way_i, valid_mask_i, flush_i,
    input  victim_way_o, full_o, hit_cnt_o, fill_cnt_o
  );

  modport slave (
    input  hit_i, hit_way_i, fill_i, fill_way_i, valid_mask_i, flush_i,
    output victim_way_o, full_o, hit_cnt_o, fill_cnt_o
  );
endinterface

// File: rtl/victim_cache_plru.sv
// Tree pseudo-LRU replacement-way generator for the 8-way victim cache, with
// saturating hit/fill counters.
module victim_cache_plru #(
  parameter int unsigned WAYS  = 8,
  parameter int unsigned WAY_W = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  victim_cache_plru_if.slave   bus
);
  localparam int unsigned NODES = WAYS - 1;

  logic [NODES-1:0] plru_q, plru_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [WAY_W-1:0] victim_c;
  logic             found_c;
  logic             r_c, s_c, t_c;

  // Point every node on way w's path away from w.
  function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] tree,
                                             input logic [WAY_W-1:0] w);
    logic [NODES-1:0] t;
    t    = tree;
    t[0] = ~w[2];
    if (w[2]) t[2] = ~w[1];
    else      t[1] = ~w[1];
    case (w[2:1])
      2'd0:    t[3] = ~w[0];
      2'd1:    t[4] = ~w[0];
      2'd2:    t[5] = ~w[0];
      default: t[6] = ~w[0];
    endcase
    return t;
  endfunction

  // Hit touch first so a same-cycle fill wins on shared nodes; flush overrides both.
  always_comb begin
    plru_d = plru_q;
    if (bus.hit_i)   plru_d = touch(plru_d, bus.hit_way_i);
    if (bus.fill_i)  plru_d = touch(plru_d, bus.fill_way_i);
    if (bus.flush_i) plru_d = '0;
  end

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    fill_cnt_d = fill_cnt_q;
    if (bus.hit_i && (hit_cnt_q != '1))   hit_cnt_d  = hit_cnt_q + CNT_W'(1);
    if (bus.fill_i && (fill_cnt_q != '1)) fill_cnt_d = fill_cnt_q + CNT_W'(1);
  end

  // Invalid ways are always preferred; the tree is only consulted when all are valid.
  always_comb begin
    victim_c = '0;
    found_c  = 1'b0;
    r_c      = plru_q[0];
    s_c      = r_c ? plru_q[2] : plru_q[1];
    case ({r_c, s_c})
      2'b00:   t_c = plru_q[3];
      2'b01:   t_c = plru_q[4];
      2'b10:   t_c = plru_q[5];
      default: t_c = plru_q[6];
    endcase
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (!found_c && !bus.valid_mask_i[i]) begin
        victim_c = WAY_W'(i);
        found_c  = 1'b1;
      end
    end
    if (!found_c) victim_c = {r_c, s_c, t_c};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      plru_q     <= '0;
      hit_cnt_q  <= '0;
      fill_cnt_q <= '0;
    end else begin
      plru_q     <= plru_d;
      hit_cnt_q  <= hit_cnt_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  assign bus.victim_way_o = victim_c;
  assign bus.full_o       = &bus.valid_mask_i;
  assign bus.hit_cnt_o    = hit_cnt_q;
  assign bus.fill_cnt_o   = fill_cnt_q;
endmodule

// File: tb/tb_victim_cache_plru.sv
// Randomized scoreboard bench for victim_cache_plru against a heap-indexed
// binary-tree reference model.
module tb_victim_cache_plru;
  localparam int unsigned WAYS  = 8;
  localparam int unsigned WAY_W = 3;
  localparam int unsigned CNT_W = 16;
  localparam int          CMAX  = 65535;

  typedef struct {
    int victim;
    int full;
    int hit_cnt;
    int fill_cnt;
  } exp_t;

  logic clk_i;
  logic rst_ni;
  victim_cache_plru_if #(.WAYS(WAYS), .WAY_W(WAY_W), .CNT_W(CNT_W)) bus ();

  victim_cache_plru #(.WAYS(WAYS), .WAY_W(WAY_W), .CNT_W(CNT_W)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int   n_checks;
  int   n_errors;
  exp_t exp_q[$];
  bit   tree[7];
  int   m_hits;
  int   m_fills;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference tree in heap order: node n has children 2n+1 (lower) and 2n+2 (upper).
  function automatic int model_victim(input logic [7:0] m);
    int node, way, b;
    for (int i = 0; i < 8; i++) if (!m[i]) return i;
    node = 0;
    way  = 0;
    for (int l = 0; l < 3; l++) begin
      b    = int'(tree[node]);
      way  = way * 2 + b;
      node = 2 * node + 1 + b;
    end
    return way;
  endfunction

  function automatic void model_touch(input int w);
    int node, b;
    node = 0;
    for (int l = 0; l < 3; l++) begin
      b          = (w >> (2 - l)) & 1;
      tree[node] = (b == 0);
      node       = 2 * node + 1 + b;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 7; i++) tree[i] = 1'b0;
    m_hits  = 0;
    m_fills = 0;
  endfunction

  // Drive one cycle, queue what the outputs must show during it, then advance the model.
  task automatic step(input bit h, input int hw, input bit f, input int fw,
                      input logic [7:0] m, input bit fl);
    exp_t e;
    bus.hit_i        = h;
    bus.hit_way_i    = 3'(hw);
    bus.fill_i       = f;
    bus.fill_way_i   = 3'(fw);
    bus.valid_mask_i = m;
    bus.flush_i      = fl;
    e.victim   = model_victim(m);
    e.full     = (m == 8'hFF) ? 1 : 0;
    e.hit_cnt  = m_hits;
    e.fill_cnt = m_fills;
    exp_q.push_back(e);
    if (fl) begin
      for (int i = 0; i < 7; i++) tree[i] = 1'b0;
    end else begin
      if (h) model_touch(hw);
      if (f) model_touch(fw);
    end
    if (h && m_hits < CMAX)  m_hits++;
    if (f && m_fills < CMAX) m_fills++;
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: outputs are compared mid-cycle against the oldest queued expectation.
  always @(negedge clk_i) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("victim_way", int'(bus.victim_way_o), e.victim);
      chk("full", int'(bus.full_o), e.full);
      chk("hit_cnt", int'(bus.hit_cnt_o), e.hit_cnt);
      chk("fill_cnt", int'(bus.fill_cnt_o), e.fill_cnt);
    end
  end

  initial begin
    int w;
    logic [7:0] m;
    n_checks = 0;
    n_errors = 0;
    model_reset();
    rst_ni           = 1'b0;
    bus.hit_i        = 1'b0;
    bus.hit_way_i    = '0;
    bus.fill_i       = 1'b0;
    bus.fill_way_i   = '0;
    bus.valid_mask_i = 8'h00;
    bus.flush_i      = 1'b0;
    #12;
    chk("reset_victim", int'(bus.victim_way_o), 0);
    chk("reset_full", int'(bus.full_o), 0);
    chk("reset_hit_cnt", int'(bus.hit_cnt_o), 0);
    chk("reset_fill_cnt", int'(bus.fill_cnt_o), 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Invalid-way priority and an all-valid mask on a cleared tree.
    step(0, 0, 0, 0, 8'h07, 0);
    step(0, 0, 0, 0, 8'hFE, 0);
    step(0, 0, 0, 0, 8'hFF, 0);

    // Eight fills, each into the presented victim: 0,4,2,6,1,5,3,7.
    for (int i = 0; i < 8; i++) step(0, 0, 1, model_victim(8'hFF), 8'hFF, 0);
    step(0, 0, 0, 0, 8'hFF, 0);

    // Same-cycle hit way 4 and fill way 1 from a cleared tree.
    step(0, 0, 0, 0, 8'hFF, 1);
    step(1, 4, 1, 1, 8'hFF, 0);
    step(0, 0, 0, 0, 8'hFF, 0);

    // Flush alongside a hit after some touches.
    step(1, 3, 0, 0, 8'hFF, 0);
    step(0, 0, 1, 6, 8'hFF, 0);
    step(1, 5, 0, 0, 8'hFF, 1);
    step(0, 0, 0, 0, 8'hFF, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      m = ($urandom_range(0, 9) < 7) ? 8'hFF : 8'($urandom);
      w = int'($urandom_range(0, 7));
      step(1'($urandom), w, 1'($urandom), int'($urandom_range(0, 7)), m,
           $urandom_range(0, 19) == 0);
    end

    // Hit counter saturation.
    for (int i = 0; i < 65540; i++) step(1, int'($urandom_range(0, 7)), 0, 0, 8'hFF, 0);

    // Asynchronous reset mid-cycle clears counters with no clock edge.
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_hit_cnt", int'(bus.hit_cnt_o), 0);
    chk("async_rst_fill_cnt", int'(bus.fill_cnt_o), 0);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    for (int i = 0; i < 20; i++) step(1'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
                                      int'($urandom_range(0, 7)), 8'hFF, 0);
    @(posedge clk_i);
    #1;
    if (exp_q.size() != 0) chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
